wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_pkg.sv | 27 ++
 rtl/wb_regfile_sb_counter.sv | 37 +++
 rtl/wb_regfile.sv | 88 ++++++++
 tb/tb_wb_regfile.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared CPU package: default datapath widths, pending-counter type and scoreboard op decode.
// Also used by the pipeline latches.
package wb_regfile_pkg;

    localparam int CPU_DATA_W = 32;
    localparam int CPU_REG_AW = 4;
    localparam int PEND_CNT_W = 2;

    typedef logic [PEND_CNT_W-1:0] pend_cnt_t;

    typedef enum logic [1:0] {
        PEND_HOLD = 2'd0,
        PEND_INC  = 2'd1,
        PEND_DEC  = 2'd2
    } pend_op_e;

    // A same-cycle issue and writeback on one register cancel out.
    function automatic pend_op_e pend_op(input logic inc, input logic dec);
        if (inc && !dec) begin
            return PEND_INC;
        end else if (dec && !inc) begin
            return PEND_DEC;
        end
        return PEND_HOLD;
    endfunction

endpackage

// File: rtl/wb_regfile_sb_counter.sv
// sb_counter: saturating pending-write counter for one register.
// err flags an overflow or underflow attempt in the current cycle.
module sb_counter
    import wb_regfile_pkg::*;
#(
    parameter int CNT_W = PEND_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    pend_op_e op;

    assign op  = pend_op(inc, dec);
    assign err = ((op == PEND_INC) && (count == CNT_MAX)) ||
                 ((op == PEND_DEC) && (count == CNT_ZERO));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= CNT_ZERO;
        end else begin
            case (op)
                PEND_INC: if (count != CNT_MAX)  count <= count + 1'b1;
                PEND_DEC: if (count != CNT_ZERO) count <= count - 1'b1;
                default:  count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: register file with a per-register pending-write scoreboard.
// Optional same-cycle writeback bypass is enabled by defining REGFILE_BYPASS_EN.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int REG_AW = CPU_REG_AW,
    parameter int CNT_W  = PEND_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mem_data_wb,
    input  logic [REG_AW-1:0] Rd_wb,
    input  logic              RdEn_wb,
    input  logic              issue_en,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] rs1_idx,
    input  logic [REG_AW-1:0] rs2_idx,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              sb_err
);

    localparam int NREG = 2 ** REG_AW;

    logic [DATA_W-1:0] regs   [NREG];
    logic [CNT_W-1:0]  counts [NREG];
    logic [NREG-1:0]   errs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (RdEn_wb) begin
            regs[Rd_wb] <= mem_data_wb;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_sb
        localparam logic [REG_AW-1:0] IDX = REG_AW'(g);

        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (issue_en && (issue_rd == IDX)),
            .dec   (RdEn_wb && (Rd_wb == IDX)),
            .count (counts[g]),
            .err   (errs[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_err <= 1'b0;
        end else if (|errs) begin
            sb_err <= 1'b1;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic hit1;
    logic hit2;

    // Writeback is ignored while reset is held, so it cannot leak through the bypass.
    assign hit1 = !rst && RdEn_wb && (Rd_wb == rs1_idx);
    assign hit2 = !rst && RdEn_wb && (Rd_wb == rs2_idx);

    always_comb begin
        rs1_data = hit1 ? mem_data_wb : regs[rs1_idx];
        rs2_data = hit2 ? mem_data_wb : regs[rs2_idx];
        rs1_busy = (counts[rs1_idx] != '0) && !(hit1 && (counts[rs1_idx] == CNT_W'(1)));
        rs2_busy = (counts[rs2_idx] != '0) && !(hit2 && (counts[rs2_idx] == CNT_W'(1)));
    end
`else
    always_comb begin
        rs1_data = regs[rs1_idx];
        rs2_data = regs[rs2_idx];
        rs1_busy = (counts[rs1_idx] != '0);
        rs2_busy = (counts[rs2_idx] != '0);
    end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios followed by random traffic checked against
// an array-based reference model of the register file and scoreboard.
module tb_wb_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_data_wb = '0;
    logic [3:0]  Rd_wb = '0;
    logic        RdEn_wb = 1'b0;
    logic        issue_en = 1'b0;
    logic [3:0]  issue_rd = '0;
    logic [3:0]  rs1_idx = '0;
    logic [3:0]  rs2_idx = '0;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        sb_err;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_regs [16];
    int          m_cnt  [16];
    bit          m_err;

    wb_regfile dut (
        .clk         (clk),
        .rst         (rst),
        .mem_data_wb (mem_data_wb),
        .Rd_wb       (Rd_wb),
        .RdEn_wb     (RdEn_wb),
        .issue_en    (issue_en),
        .issue_rd    (issue_rd),
        .rs1_idx     (rs1_idx),
        .rs2_idx     (rs2_idx),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .sb_err      (sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = '0;
            m_cnt[i]  = 0;
        end
        m_err = 1'b0;
    endtask

    // Pending count is (issues - writebacks), clamped to 0..3; clamping is an error.
    task automatic m_update();
        for (int i = 0; i < 16; i++) begin
            int d;
            d = 0;
            if (issue_en && issue_rd == 4'(i)) d = d + 1;
            if (RdEn_wb && Rd_wb == 4'(i))     d = d - 1;
            if (m_cnt[i] + d > 3 || m_cnt[i] + d < 0) m_err = 1'b1;
            else m_cnt[i] = m_cnt[i] + d;
        end
        if (RdEn_wb) m_regs[Rd_wb] = mem_data_wb;
    endtask

    function automatic logic [31:0] exp_data(input logic [3:0] idx);
        if (BYP && !rst && RdEn_wb && Rd_wb == idx) return mem_data_wb;
        return m_regs[idx];
    endfunction

    function automatic logic exp_busy(input logic [3:0] idx);
        if (BYP && !rst && RdEn_wb && Rd_wb == idx && m_cnt[idx] == 1) return 1'b0;
        return m_cnt[idx] != 0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".rs1_data"}, rs1_data, exp_data(rs1_idx));
        chk({tag, ".rs2_data"}, rs2_data, exp_data(rs2_idx));
        chk({tag, ".rs1_busy"}, 32'(rs1_busy), 32'(exp_busy(rs1_idx)));
        chk({tag, ".rs2_busy"}, 32'(rs2_busy), 32'(exp_busy(rs2_idx)));
        chk({tag, ".sb_err"}, 32'(sb_err), 32'(m_err));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst) m_update();
        #1;
    endtask

    task automatic idle_inputs();
        RdEn_wb  = 1'b0;
        issue_en = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_reset();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_all("reset_init");

        // Write R5, then reset asynchronously between edges.
        RdEn_wb = 1'b1; Rd_wb = 4'd5; mem_data_wb = 32'hDEADBEEF;
        cycle();
        idle_inputs(); rs1_idx = 4'd5;
        #1;
        chk("r5_written", rs1_data, 32'hDEADBEEF);
        chk("wb_underflow_err", 32'(sb_err), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_data", rs1_data, 32'h0);
        chk("async_rst_busy", 32'({rs1_busy, rs2_busy}), 32'd0);
        chk("async_rst_err", 32'(sb_err), 32'd0);
        m_reset();
        #1;
        rst = 1'b0;

        // Plain write/read.
        cycle();
        RdEn_wb = 1'b1; Rd_wb = 4'd3; mem_data_wb = 32'h12345678;
        cycle();
        idle_inputs(); rs1_idx = 4'd3; rs2_idx = 4'd5;
        #1;
        chk("r3_read", rs1_data, 32'h12345678);
        chk("r5_unchanged", rs2_data, 32'h0);
        check_all("write_read");
        do_reset();

        // Scoreboard lifetime of one pending write to R7.
        cycle();
        issue_en = 1'b1; issue_rd = 4'd7; rs2_idx = 4'd7;
        #1;
        chk("r7_busy_at_issue", 32'(rs2_busy), 32'd0);
        cycle();
        idle_inputs();
        #1;
        chk("r7_busy_pending", 32'(rs2_busy), 32'd1);
        cycle();
        RdEn_wb = 1'b1; Rd_wb = 4'd7; mem_data_wb = 32'hCAFEF00D;
        #1;
        chk("r7_busy_wb_cycle", 32'(rs2_busy), BYP ? 32'd0 : 32'd1);
        cycle();
        idle_inputs();
        #1;
        chk("r7_busy_after_wb", 32'(rs2_busy), 32'd0);
        chk("r7_data_after_wb", rs2_data, 32'hCAFEF00D);
        chk("r7_no_err", 32'(sb_err), 32'd0);

        // Same-cycle bypass behaviour.
        issue_en = 1'b1; issue_rd = 4'd7;
        cycle();
        idle_inputs();
        RdEn_wb = 1'b1; Rd_wb = 4'd7; mem_data_wb = 32'hA5A5A5A5; rs1_idx = 4'd7;
        #1;
        chk("bypass_data", rs1_data, BYP ? 32'hA5A5A5A5 : 32'hCAFEF00D);
        chk("bypass_busy", 32'(rs1_busy), BYP ? 32'd0 : 32'd1);
        cycle();
        idle_inputs();
        #1;
        check_all("post_bypass");

        // Simultaneous issue and writeback on R2 at count 1.
        issue_en = 1'b1; issue_rd = 4'd2;
        cycle();
        RdEn_wb = 1'b1; Rd_wb = 4'd2; mem_data_wb = 32'h11112222;
        cycle();
        idle_inputs(); rs1_idx = 4'd2;
        #1;
        chk("simul_busy", 32'(rs1_busy), 32'd1);
        chk("simul_err", 32'(sb_err), 32'd0);
        chk("simul_data", rs1_data, 32'h11112222);
        RdEn_wb = 1'b1; Rd_wb = 4'd2; mem_data_wb = 32'h33334444;
        cycle();
        idle_inputs();
        #1;
        chk("simul_drained", 32'(rs1_busy), 32'd0);

        // Overflow on R9, then underflow on R4, sticky until reset.
        issue_en = 1'b1; issue_rd = 4'd9; rs1_idx = 4'd9;
        repeat (3) cycle();
        #1;
        chk("r9_at_max_no_err", 32'(sb_err), 32'd0);
        cycle();
        idle_inputs();
        #1;
        chk("overflow_err", 32'(sb_err), 32'd1);
        chk("overflow_busy", 32'(rs1_busy), 32'd1);
        check_all("overflow");
        repeat (3) cycle();
        chk("err_sticky", 32'(sb_err), 32'd1);
        do_reset();
        #1;
        chk("err_cleared", 32'(sb_err), 32'd0);
        chk("r9_cleared", 32'(rs1_busy), 32'd0);
        cycle();
        RdEn_wb = 1'b1; Rd_wb = 4'd4; mem_data_wb = 32'h44444444;
        cycle();
        idle_inputs();
        #1;
        chk("underflow_err", 32'(sb_err), 32'd1);
        do_reset();

        // Random traffic with occasional mid-run resets.
        for (int n = 0; n < 600; n++) begin
            cycle();
            if ($urandom_range(0, 120) == 0) begin
                do_reset();
            end
            issue_en    = ($urandom_range(0, 2) == 0);
            issue_rd    = 4'($urandom_range(0, 15));
            RdEn_wb     = ($urandom_range(0, 2) == 0);
            Rd_wb       = ($urandom_range(0, 1) == 0) ? issue_rd : 4'($urandom_range(0, 15));
            mem_data_wb = $urandom;
            rs1_idx     = ($urandom_range(0, 1) == 0) ? Rd_wb : 4'($urandom_range(0, 15));
            rs2_idx     = 4'($urandom_range(0, 15));
            #1;
            check_all("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
